// File: rtl/lc3_wb_pkg.sv
// Shared types and helpers for the LC-3 writeback stage.
package lc3_wb_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_addr_t;
  typedef logic [2:0]  nzp_t;

  localparam nzp_t NZP_RESET = 3'b010;

  typedef struct packed {
    reg_addr_t dr;
    word_t     data;
    logic      setcc;
  } wb_entry_t;

  // One-hot {N,Z,P} classification of a two's-complement word.
  function automatic nzp_t calc_nzp(input word_t data);
    nzp_t cc;
    if (data[15]) begin
      cc = 3'b100;
    end else if (data == '0) begin
      cc = 3'b010;
    end else begin
      cc = 3'b001;
    end
    return cc;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; pointers wrap modulo DEPTH.
module wb_fifo
  import lc3_wb_pkg::*;
#(
  parameter  int unsigned DEPTH   = 2,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned COUNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  wb_entry_t          wr_entry,
  output wb_entry_t          rd_entry,
  output logic [COUNT_W-1:0] count
);

  wb_entry_t          mem_q [DEPTH];
  wb_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;

  // Guard against overflow/underflow regardless of what the caller asks for.
  always_comb begin
    do_push  = push && (count_q != COUNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + COUNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 regfile write-side driver: result FIFO, registered write port,
// NZP condition codes and a per-register pending-write scoreboard.
module lc3_writeback
  import lc3_wb_pkg::*;
#(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned NREG    = 8,
  parameter  int unsigned DEPTH   = 2,
  parameter  int unsigned CNT_W   = 2,
  localparam int unsigned COUNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [2:0]         res_dr,
  input  logic [DATA_W-1:0]  res_data,
  input  logic               res_setcc,
  input  logic               claim_valid,
  input  logic [2:0]         claim_dr,
  output logic [NREG-1:0]    busy,
  output logic               writeEN,
  output logic [2:0]         wrAddr,
  output logic [DATA_W-1:0]  wrData,
  output logic [2:0]         nzp,
  output logic [COUNT_W-1:0] count,
  output logic               sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_entry_t          in_entry;
  wb_entry_t          head;
  logic               fifo_push;
  logic               fifo_pop;
  logic [COUNT_W-1:0] fifo_count;

  logic               we_q, we_d;
  reg_addr_t          addr_q, addr_d;
  word_t              data_q, data_d;
  nzp_t               nzp_q, nzp_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q [NREG];
  logic [CNT_W-1:0]   cnt_d [NREG];
  logic [NREG-1:0]    claim_hit;
  logic [NREG-1:0]    retire_hit;

  assign in_entry  = '{dr: res_dr, data: word_t'(res_data), setcc: res_setcc};
  assign res_ready = rst && (fifo_count < COUNT_W'(DEPTH));
  assign fifo_push = res_valid && res_ready;
  assign fifo_pop  = (fifo_count != '0);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wr_entry (in_entry),
    .rd_entry (head),
    .count    (fifo_count)
  );

  // Head of the FIFO drives the write port for the following cycle.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    nzp_d  = nzp_q;
    if (fifo_pop) begin
      we_d   = 1'b1;
      addr_d = head.dr;
      data_d = head.data;
      if (head.setcc) begin
        nzp_d = calc_nzp(head.data);
      end
    end
  end

  always_comb begin
    claim_hit  = '0;
    retire_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      claim_hit[r]  = claim_valid && (claim_dr == reg_addr_t'(r));
      retire_hit[r] = we_q && (addr_q == reg_addr_t'(r));
    end
  end

  // Saturating pending counters; a same-edge claim and retire cancel out.
  always_comb begin
    err_d = err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (claim_hit[r] && !retire_hit[r]) begin
        if (cnt_q[r] == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
      end else if (retire_hit[r] && !claim_hit[r]) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      nzp_q  <= NZP_RESET;
      err_q  <= 1'b0;
      cnt_q  <= '{default: '0};
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      nzp_q  <= nzp_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign writeEN = we_q;
  assign wrAddr  = addr_q;
  assign wrData  = DATA_W'(data_q);
  assign nzp     = nzp_q;
  assign count   = fifo_count;
  assign sb_err  = err_q;

endmodule
